// File: rtl/alu_pack.sv
// rtl/alu_pack.sv - shared op and FSM state types for the sequential ALU
package alu_pack;

   typedef enum logic [4:0] {
      amp, lor, flp, eor, rsc, lsc, rol, ror,
      add, sub, eql, eqlk, revx, revy, parx, pary, mul
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      ROT,
      MUL
   } alu_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-add multiplier, one multiplier bit per clock
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               go,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand;
   logic [CW-1:0]    cnt;

   // One iteration: add the multiplicand into the high half when the current
   // low bit is set, then shift the whole accumulator right by one.
   function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                               input logic [WIDTH-1:0]   m);
      logic [WIDTH:0] s;
      s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      return {s, p[WIDTH-1:1]};
   endfunction

   // Load performs the first iteration so the product is ready WIDTH-1 edges later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= 1'b0;
         if (go && !busy) begin
            mcand   <= a;
            product <= step({{WIDTH{1'b0}}, b}, a);
            cnt     <= CW'(WIDTH - 1);
            busy    <= 1'b1;
         end else if (busy) begin
            product <= step(product, mcand);
            cnt     <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - clocked ALU with registered results, iterative rotate and multiply
module alu_seq
   import alu_pack::*;
#(
   parameter int WIDTH   = 8,
   parameter int EQ_BITS = 5,
   parameter int ROT_W   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  alu_op_t          op,
   input  logic             alu_rs,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] r_out,
   output logic [WIDTH-1:0] s_out,
   output logic             carry,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   alu_state_t       state;

   // single-cycle op captured at accept, written at the following edge
   alu_op_t          lat_op;
   logic [WIDTH-1:0] lat_x;
   logic [WIDTH-1:0] lat_y;
   logic             lat_rs;
   logic             pend;

   logic [WIDTH-1:0] rot_val;
   logic [ROT_W-1:0] rot_cnt;
   logic             rot_left;
   logic             rot_rs;

   logic [WIDTH-1:0] res;
   logic             res_c;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] rot_next;

   logic [2*WIDTH-1:0] product;
   logic               mult_busy;
   logic               mult_done;

   logic             accept;
   logic             mul_go;
   logic [ROT_W-1:0] amt;

   assign accept = start && !busy && (state == IDLE);
   assign mul_go = accept && (op == mul);
   assign amt    = y[ROT_W-1:0];

   seq_multiplier #(.WIDTH(WIDTH)) u_mult (
      .clk     (clk),
      .rst_n   (rst_n),
      .go      (mul_go),
      .a       (x),
      .b       (y),
      .busy    (mult_busy),
      .done    (mult_done),
      .product (product)
   );

   // Single-cycle result and carry from the latched operands
   always_comb begin
      res   = '0;
      res_c = 1'b0;
      sum   = '0;
      case (lat_op)
         amp:  res = lat_x & lat_y;
         lor:  res = lat_x | lat_y;
         eor:  res = lat_x ^ lat_y;
         flp:  res = ~lat_x;
         rsc: begin
            res   = {lat_y[0], lat_x[WIDTH-1:1]};
            res_c = lat_x[0];
         end
         lsc: begin
            res   = {lat_x[WIDTH-2:0], lat_y[WIDTH-1]};
            res_c = lat_x[WIDTH-1];
         end
         rol, ror: res = lat_x;
         add: begin
            sum   = {1'b0, lat_x} + {1'b0, lat_y};
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
         end
         sub: begin
            sum   = {1'b0, lat_x} + {1'b0, ~lat_y} + (WIDTH+1)'(1);
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
         end
         eql:  res[0] = (lat_x == lat_y);
         eqlk: res[0] = (lat_x[EQ_BITS-1:0] == lat_y[EQ_BITS-1:0]);
         revx: for (int i = 0; i < WIDTH; i++) res[i] = lat_x[WIDTH-1-i];
         revy: for (int i = 0; i < WIDTH; i++) res[i] = lat_y[WIDTH-1-i];
         parx: res[0] = ^lat_x;
         pary: res[0] = ^lat_y;
         default: res = '0;
      endcase
   end

   // One-bit rotation step of the in-flight rotate operand
   always_comb begin
      rot_next = rot_left ? {rot_val[WIDTH-2:0], rot_val[WIDTH-1]}
                          : {rot_val[0], rot_val[WIDTH-1:1]};
   end

   // Control FSM plus result/flag registers; done pulses one cycle per completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         r_out    <= '0;
         s_out    <= '0;
         carry    <= 1'b0;
         zero     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         lat_op   <= amp;
         lat_x    <= '0;
         lat_y    <= '0;
         lat_rs   <= 1'b0;
         pend     <= 1'b0;
         rot_val  <= '0;
         rot_cnt  <= '0;
         rot_left <= 1'b0;
         rot_rs   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (pend) begin
            if (lat_rs) s_out <= res;
            else        r_out <= res;
            carry <= res_c;
            zero  <= (res == '0);
            done  <= 1'b1;
            pend  <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  if (op == mul) begin
                     state <= MUL;
                     busy  <= 1'b1;
                  end else if ((op == rol || op == ror) && amt != '0) begin
                     rot_val  <= x;
                     rot_cnt  <= amt;
                     rot_left <= (op == rol);
                     rot_rs   <= alu_rs;
                     state    <= ROT;
                     busy     <= 1'b1;
                  end else begin
                     lat_op <= op;
                     lat_x  <= x;
                     lat_y  <= y;
                     lat_rs <= alu_rs;
                     pend   <= 1'b1;
                  end
               end
            end
            ROT: begin
               rot_val <= rot_next;
               rot_cnt <= rot_cnt - ROT_W'(1);
               if (rot_cnt == ROT_W'(1)) begin
                  if (rot_rs) s_out <= rot_next;
                  else        r_out <= rot_next;
                  carry <= 1'b0;
                  zero  <= (rot_next == '0);
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            MUL: begin
               if (mult_done && !mult_busy) begin
                  r_out <= product[WIDTH-1:0];
                  s_out <= product[2*WIDTH-1:WIDTH];
                  carry <= 1'b0;
                  zero  <= (product == '0);
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH 8 and 16
module tb_alu_seq;
   import alu_pack::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   alu_op_t    op = amp;
   logic       alu_rs = 1'b0;
   logic [7:0] x = '0;
   logic [7:0] y = '0;
   logic [7:0] r_out, s_out;
   logic       carry, zero, busy, done;

   logic        start16 = 1'b0;
   alu_op_t     op16 = amp;
   logic        rs16 = 1'b0;
   logic [15:0] x16 = '0;
   logic [15:0] y16 = '0;
   logic [15:0] r16, s16;
   logic        carry16, zero16, busy16, done16;

   int total = 0;
   int bad   = 0;
   int lat, bc, dcnt;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .alu_rs(alu_rs),
      .x(x), .y(y), .r_out(r_out), .s_out(s_out),
      .carry(carry), .zero(zero), .busy(busy), .done(done)
   );

   alu_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .alu_rs(rs16),
      .x(x16), .y(y16), .r_out(r16), .s_out(s16),
      .carry(carry16), .zero(zero16), .busy(busy16), .done(done16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called #1 after an edge: presents the op, counts edges to done and busy samples.
   task automatic run(input alu_op_t o, input logic rs, input logic [7:0] a,
                      input logic [7:0] b, output int l, output int bcnt);
      op = o; alu_rs = rs; x = a; y = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; x = ~a; y = ~b; op = add;
      bcnt = busy ? 1 : 0;
      l = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) begin
            l = k;
            break;
         end
         if (busy) bcnt++;
      end
   endtask

   initial begin
      #2;
      chk("rst_r", r_out, 8'h00);
      chk("rst_s", s_out, 8'h00);
      chk("rst_flags", {carry, zero, busy, done}, 4'b0000);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      run(add, 1'b0, 8'hF0, 8'h20, lat, bc);
      chk("add_lat", lat, 1);
      chk("add_r", r_out, 8'h10);
      chk("add_c", carry, 1'b1);
      chk("add_z", zero, 1'b0);
      chk("add_s_hold", s_out, 8'h00);

      run(sub, 1'b1, 8'h05, 8'h05, lat, bc);
      chk("sub0_s", s_out, 8'h00);
      chk("sub0_zc", {zero, carry}, 2'b11);
      chk("sub0_r_hold", r_out, 8'h10);

      run(sub, 1'b1, 8'h03, 8'h05, lat, bc);
      chk("sub1_s", s_out, 8'hFE);
      chk("sub1_zc", {zero, carry}, 2'b00);

      run(rol, 1'b0, 8'h81, 8'h03, lat, bc);
      chk("rol_lat", lat, 3);
      chk("rol_busy", bc, 3);
      chk("rol_busy_done", busy, 1'b0);
      chk("rol_r", r_out, 8'h0C);
      chk("rol_c", carry, 1'b0);

      run(ror, 1'b0, 8'h5A, 8'h00, lat, bc);
      chk("ror0_lat", lat, 1);
      chk("ror0_busy", bc, 0);
      chk("ror0_r", r_out, 8'h5A);

      run(ror, 1'b1, 8'h01, 8'h01, lat, bc);
      chk("ror1_lat", lat, 1);
      chk("ror1_busy", bc, 1);
      chk("ror1_s", s_out, 8'h80);

      run(eqlk, 1'b0, 8'h3F, 8'h1F, lat, bc);
      chk("eqlk_r", r_out, 8'h01);
      run(eql, 1'b1, 8'h3F, 8'h1F, lat, bc);
      chk("eql_s", s_out, 8'h00);
      chk("eql_z", zero, 1'b1);

      run(lsc, 1'b0, 8'h81, 8'h80, lat, bc);
      chk("lsc_r", r_out, 8'h03);
      chk("lsc_c", carry, 1'b1);
      run(rsc, 1'b1, 8'h03, 8'h00, lat, bc);
      chk("rsc_s", s_out, 8'h01);
      chk("rsc_c", carry, 1'b1);

      run(revx, 1'b0, 8'h01, 8'h00, lat, bc);
      chk("revx_r", r_out, 8'h80);
      run(parx, 1'b1, 8'h07, 8'h00, lat, bc);
      chk("parx_s", s_out, 8'h01);
      run(flp, 1'b0, 8'hFF, 8'h00, lat, bc);
      chk("flp_r", r_out, 8'h00);
      chk("flp_zc", {zero, carry}, 2'b10);

      run(alu_op_t'(5'd20), 1'b1, 8'hFF, 8'hFF, lat, bc);
      chk("undef_lat", lat, 1);
      chk("undef_s", s_out, 8'h00);
      chk("undef_z", zero, 1'b1);

      run(add, 1'b0, 8'hFF, 8'h01, lat, bc);
      chk("addw_r", r_out, 8'h00);
      chk("addw_zc", {zero, carry}, 2'b11);

      // multiply with a stray add request while busy
      op = mul; alu_rs = 1'b1; x = 8'hFF; y = 8'hFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; x = 8'h00; y = 8'h00;
      bc = busy ? 1 : 0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
         if (busy) bc++;
         if (k == 2) begin
            op = add; alu_rs = 1'b0; x = 8'h01; y = 8'h01; start = 1'b1;
         end
         if (k == 3) start = 1'b0;
      end
      start = 1'b0;
      chk("mul_lat", lat, 8);
      chk("mul_busy", bc, 8);
      chk("mul_r", r_out, 8'h01);
      chk("mul_s", s_out, 8'hFE);
      chk("mul_zc", {zero, carry}, 2'b00);

      // reset in the middle of a multiply
      op = mul; x = 8'h0F; y = 8'h0F; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_r", r_out, 8'h00);
      chk("arst_s", s_out, 8'h00);
      chk("arst_flags", {carry, zero, busy, done}, 4'b0000);
      @(negedge clk); rst_n = 1'b1;
      dcnt = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) dcnt++;
      end
      chk("arst_no_done", dcnt, 0);
      chk("arst_r_hold", r_out, 8'h00);
      run(add, 1'b0, 8'h01, 8'h01, lat, bc);
      chk("post_lat", lat, 1);
      chk("post_r", r_out, 8'h02);

      // 16-bit instance wraparound
      op16 = add; rs16 = 1'b0; x16 = 16'hFFFF; y16 = 16'h0001; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done16) begin
            lat = k;
            break;
         end
      end
      chk("w16_lat", lat, 1);
      chk("w16_r", r16, 16'h0000);
      chk("w16_zc", {zero16, carry16}, 2'b11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
